// File: rtl/pe_seq_pkg.sv
// Shared types and constants for the PE accumulation sequencer.
// Defines the job FSM states, the PE mode codes and the operand lane geometry.
package pe_seq_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WAIT,
    FEED,
    DRAIN,
    HOLD
  } state_t;

  localparam logic [1:0] MODE_FP16 = 2'b00;
  localparam logic [1:0] MODE_FP32 = 2'b01;

  localparam int LANES  = 16;
  localparam int LANE_W = 16;
  localparam int BEAT_W = LANES * LANE_W;

  function automatic logic mode_ok(input logic [1:0] mode);
    return (mode == MODE_FP16) || (mode == MODE_FP32);
  endfunction

endpackage

// File: rtl/pe_op_fifo.sv
// Operand FIFO holding paired A/B beats ahead of the PE.
// Pointers, count and ready are reset; the storage array is not.
module pe_op_fifo
  import pe_seq_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int W     = 2 * BEAT_W,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             push,
  input  logic             pop,
  input  logic [W-1:0]     wr_data,
  output logic [W-1:0]     rd_data,
  output logic             ready,
  output logic [CNT_W-1:0] count
);

  localparam int               PTR_W = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] FULL  = CNT_W'(DEPTH);

  logic [W-1:0]     mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;
  logic [CNT_W-1:0] count_next;

  assign do_push = push && ready;
  assign do_pop  = pop && (count != '0);
  assign rd_data = mem[rd_ptr];

  always_comb begin
    count_next = count;
    if (do_push && !do_pop) begin
      count_next = count + 1'b1;
    end else if (!do_push && do_pop) begin
      count_next = count - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  // ready is registered from the next count so it reads 0 while in reset
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      ready  <= 1'b0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      count <= count_next;
      ready <= (count_next != FULL);
    end
  end

endmodule

// File: rtl/pe_acc_sequencer.sv
// Job-level controller for one PE_16in_top: buffers operand beats, feeds a gap-free burst,
// captures the PE result and returns it over valid/ready. PE_WDOG_EN enables a DRAIN watchdog.
module pe_acc_sequencer
  import pe_seq_pkg::*;
#(
  parameter int DEPTH    = 8,
  parameter int ACC_W    = 4,
  parameter int WDOG_CYC = 64
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              job_valid,
  output logic              job_ready,
  input  logic [1:0]        job_mode,
  input  logic [ACC_W-1:0]  job_len,
  input  logic              op_valid,
  output logic              op_ready,
  input  logic [BEAT_W-1:0] op_a,
  input  logic [BEAT_W-1:0] op_b,
  output logic [1:0]        pe_mode_sel,
  output logic [ACC_W-1:0]  pe_acc_num,
  output logic [BEAT_W-1:0] pe_A,
  output logic [BEAT_W-1:0] pe_B,
  input  logic              pe_out_en,
  input  logic [63:0]       pe_result,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [63:0]       res_data,
  output logic              res_err
);

  localparam int CNT_W = $clog2(DEPTH) + 1;

  state_t              state;
  logic [ACC_W-1:0]    len_q;
  logic [1:0]          mode_q;
  logic [ACC_W-1:0]    beat_cnt;
  logic                stray_oen;

  logic                fifo_pop;
  logic [2*BEAT_W-1:0] fifo_rd;
  logic [CNT_W-1:0]    fifo_count;
  logic [BEAT_W-1:0]   fifo_a;
  logic [BEAT_W-1:0]   fifo_b;
  logic                bad_job;
  logic                count_ge_len;
  logic                job_fire;

  pe_op_fifo #(
    .DEPTH (DEPTH),
    .W     (2 * BEAT_W),
    .CNT_W (CNT_W)
  ) u_fifo (
    .clk     (clk),
    .rstn    (rstn),
    .push    (op_valid),
    .pop     (fifo_pop),
    .wr_data ({op_a, op_b}),
    .rd_data (fifo_rd),
    .ready   (op_ready),
    .count   (fifo_count)
  );

  assign fifo_a       = fifo_rd[2*BEAT_W-1:BEAT_W];
  assign fifo_b       = fifo_rd[BEAT_W-1:0];
  assign job_fire     = job_valid && job_ready;
  assign bad_job      = (job_len == '0) || (32'(job_len) > 32'(DEPTH)) || !mode_ok(job_mode);
  assign count_ge_len = 32'(fifo_count) >= 32'(len_q);

  // The first pop happens on the WAIT->FEED edge so beat N is on pe_A while beat_cnt reads N
  assign fifo_pop = ((state == WAIT) && count_ge_len) ||
                    ((state == FEED) && (beat_cnt != ACC_W'(1)));

`ifdef PE_WDOG_EN
  localparam int WD_W = $clog2(WDOG_CYC + 1);
  logic [WD_W-1:0] wdog;
`else
  logic unused_cfg;
  assign unused_cfg = (WDOG_CYC == 0);
`endif

  // stray_oen is a debug-only flag, kept for observation in simulation
  logic unused_dbg;
  assign unused_dbg = stray_oen;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state       <= IDLE;
      len_q       <= '0;
      mode_q      <= '0;
      beat_cnt    <= '0;
      stray_oen   <= 1'b0;
      job_ready   <= 1'b0;
      pe_mode_sel <= '0;
      pe_acc_num  <= '0;
      pe_A        <= '0;
      pe_B        <= '0;
      res_valid   <= 1'b0;
      res_data    <= '0;
      res_err     <= 1'b0;
`ifdef PE_WDOG_EN
      wdog        <= '0;
`endif
    end else begin
      if (pe_out_en && (state != DRAIN)) begin
        stray_oen <= 1'b1;
      end

      case (state)
        IDLE: begin
          job_ready <= 1'b1;
          if (job_fire) begin
            job_ready <= 1'b0;
            len_q     <= job_len;
            mode_q    <= job_mode;
            if (bad_job) begin
              res_data  <= '0;
              res_err   <= 1'b1;
              res_valid <= 1'b1;
              state     <= HOLD;
            end else begin
              state <= WAIT;
            end
          end
        end

        // Hold off until every beat of the job is buffered so the feed never stalls
        WAIT: begin
          if (count_ge_len) begin
            pe_A        <= fifo_a;
            pe_B        <= fifo_b;
            beat_cnt    <= len_q;
            pe_mode_sel <= mode_q;
            pe_acc_num  <= len_q;
            state       <= FEED;
          end
        end

        FEED: begin
          if (beat_cnt != ACC_W'(1)) begin
            pe_A     <= fifo_a;
            pe_B     <= fifo_b;
            beat_cnt <= beat_cnt - 1'b1;
          end else begin
            pe_A     <= '0;
            pe_B     <= '0;
            beat_cnt <= '0;
            state    <= DRAIN;
`ifdef PE_WDOG_EN
            wdog     <= '0;
`endif
          end
        end

        DRAIN: begin
          if (pe_out_en) begin
            res_data    <= pe_result;
            res_err     <= 1'b0;
            res_valid   <= 1'b1;
            pe_mode_sel <= '0;
            pe_acc_num  <= '0;
            state       <= HOLD;
          end
`ifdef PE_WDOG_EN
          else if (wdog == WD_W'(WDOG_CYC - 1)) begin
            res_data    <= '0;
            res_err     <= 1'b1;
            res_valid   <= 1'b1;
            pe_mode_sel <= '0;
            pe_acc_num  <= '0;
            state       <= HOLD;
          end else begin
            wdog <= wdog + 1'b1;
          end
`endif
        end

        HOLD: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            job_ready <= 1'b1;
            state     <= IDLE;
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
